dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the MIPS core. It answers load/store requests over a valid/ready request channel and a single-cycle response strobe, and inserts a fixed, parameterised number of wait states. It replaces the combinational data memory behind the processor's memory stage, so the core must stall on `req_ready`/`rsp_valid`. It also reports misaligned and out-of-range accesses instead of silently aliasing them.

---
 rtl/dmem_pkg.sv | 6 +
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the multi-cycle data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous byte-enabled write, synchronous read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // Contents are deliberately not reset; read data holds until the next read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with LATENCY wait states and error reporting.
// Optional byte strobes: define DMEM_BYTE_STROBE_EN to add the req_be port.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [BE_W-1:0]   req_be,
`endif
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output dmem_state_t       dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Handshake: a request is taken on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE. rsp_valid is a one-cycle strobe in RESP with
  // no backpressure; rsp_rdata/rsp_err hold until the next response.

  dmem_state_t       r_state, w_state_next;
  logic [CW-1:0]     r_cnt, w_cnt_next;
  logic              w_accept, w_go_resp;

  logic              r_we;
  logic [31:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_rsp_err, r_rsp_load;

  logic              w_err;
  logic [WORD_W-1:0] w_arr_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_go_resp    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = WAIT;
          w_cnt_next   = CW'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_go_resp    = 1'b1;
          w_state_next = RESP;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
      r_be    <= req_be;
`else
      r_be    <= {BE_W{1'b1}};
`endif
    end
  end

  // Full 30-bit word index compare so high addresses never alias into the array.
  assign w_err = (r_addr[1:0] != 2'b00) ||
                 ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_err  <= 1'b0;
      r_rsp_load <= 1'b0;
    end else if (w_go_resp) begin
      r_rsp_err  <= w_err;
      r_rsp_load <= !w_err && !r_we;
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .i_we    (w_go_resp && r_we && !w_err),
    .i_be    (r_be),
    .i_re    (w_go_resp && !r_we && !w_err),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

  assign req_ready = (r_state == IDLE) && !reset;
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rsp_load ? w_arr_rdata : '0;
  assign rsp_err   = r_rsp_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2).
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = 4'hF;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  dmem_state_t dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
  endtask

  // Issue one request from IDLE and check latency, data and error flag.
  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    wait_ready(name);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (rsp_valid !== 1'b1 && lat < 10);
    check({name, "_latency"}, 32'(lat), 32'd2);
    check({name, "_rdata"}, rsp_rdata, exp_rdata);
    check({name, "_err"}, 32'(rsp_err), {31'd0, exp_err});
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0013, 32'h1234_5678, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0400, 32'h0,         32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0,         32'h0BAD_F00D, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,         32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hA5A5_5A5A, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_5A5A, 1'b0});

    // Reset values while reset is held and after release.
    repeat (2) @(negedge clk);
    check("rst_ready_held", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready_release", 32'(req_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    for (int i = 0; i < vecs.size(); i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, 4'hF,
             vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Back-to-back: inputs changed during WAIT must be ignored.
    wait_ready("b2b");
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0010;
    @(posedge clk);
    #1;
    req_addr  = 32'h0000_03FC;
    req_wdata = 32'hFFFF_FFFF;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_c%0d", i), 32'(req_ready), (i == 4) ? 32'd1 : 32'd0);
      if (i == 3) begin
        check("b2b_rsp1_valid", 32'(rsp_valid), 32'd1);
        check("b2b_rsp1_rdata", rsp_rdata, 32'hDEAD_BEEF);
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_accepted", 32'(dbg_state), 32'(WAIT));
    @(negedge clk);
    @(negedge clk);
    check("b2b_rsp2_valid", 32'(rsp_valid), 32'd1);
    check("b2b_rsp2_rdata", rsp_rdata, 32'h0BAD_F00D);

    // Reset in WAIT discards a pending store.
    do_req("pre_store", 1'b1, 32'h0000_0020, 32'h0, 4'hF, 32'h0, 1'b0);
    wait_ready("mid_rst");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (rsp_valid === 1'b1) seen++;
      end
      check("mid_rst_no_rsp", 32'(seen), 32'd0);
    end
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    do_req("mid_rst_load", 1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'h0, 1'b0);

`ifdef DMEM_BYTE_STROBE_EN
    do_req("be_full", 1'b1, 32'h0000_0030, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    do_req("be_low",  1'b1, 32'h0000_0030, 32'hAABB_CCDD, 4'b0011, 32'h0, 1'b0);
    do_req("be_none", 1'b1, 32'h0000_0030, 32'h9999_9999, 4'b0000, 32'h0, 1'b0);
    do_req("be_load", 1'b0, 32'h0000_0030, 32'h0, 4'b0000, 32'h1122_CCDD, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
